stats_sequencer: RTL and testbench
==================================

# stats_sequencer

Single-clock controller that sequences the switch-entry statistics calculator: it takes debounced button levels and the 8-bit switch bus, collects N samples, then schedules one shared iterative divider and an iterative square-root unit to produce SUM, AVG, SUMSQ and STD. It sits directly after the debounce stage and before the LED outputs, in the 125 MHz domain. All buttons are edge-detected on `clk`; no logic is clocked from button signals.

## Interface
- `DATA_W`, 8, sample and N width.
- `ACC_W`, 24, accumulator width; divider and sqrt width is `ACC_W+DATA_W` (32).
- `clk`  in  1  system clock (125 MHz internal clock).
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high.
- `btnc`  in  1  debounced level; a rising edge means "enter value".
- `btnr`  in  1  debounced level; a rising edge means "display result".
- `sw`  in  DATA_W  sample / N value; `sw[1:0]` is the display select.
- `led`  out  8  registered display value.
- `busy`  out  1  computation in progress.
- `done`  out  1  results valid.

## Operation
- Edge detect:
  - Registers `btnc_q` and `btnr_q` reset to 0.
  - `press = btn & ~btn_q`.
  - A button held high through reset release counts as one press.
- States:
  - `LOAD_N`: a btnc press with `sw!=0` sets `n=rem=sw`, clears sum, sumsq, avg and std, then goes to `COLLECT`. A press with `sw==0` is ignored.
  - `COLLECT`: each btnc press does `sum+=sw`, `sumsq+=sw*sw` and `rem-=1`. The press with `rem==1` goes to `DIV_AVG`.
  - `DIV_AVG`: restoring divide `sum/n`, one quotient bit per cycle, 32 cycles. Result: `avg=floor(sum/n)`.
  - `DIV_VAR`: the same divider unit computes `(n*sumsq - sum*sum) / (n*n)`, 32 cycles. Operands are loaded on entry. The numerator is never negative.
  - `SQRT`: bit-serial integer square root of the variance quotient, 16 cycles. Result: `std=floor(sqrt(var))`.
  - `DONE`: `done=1`. A btnc press with `sw!=0` behaves exactly as a press in `LOAD_N`.
- Widths:
  - sum and sumsq are `ACC_W` bits and never overflow for N≤255: maximum sum is 65025, maximum sumsq is 16581375.
  - Products are computed at 32 bits.
- btnc presses while `busy` are ignored and are not queued.
- Display: a btnr press in any state loads `led` with the low 8 bits of the selected value:
  - `sw[1:0]=00` → sum
  - `01` → avg
  - `10` → sumsq
  - `11` → std
  - During collection the display shows the running sum and sumsq; avg and std read 0 until `done`.
- Simultaneous btnc and btnr presses in the same cycle are both processed. `led` takes the value from before the btnc update.

## Timing
- Reset values:
  - `led=0`, `busy=0`, `done=0`.
  - State is `LOAD_N`; all accumulators are 0.
- Reset mid-operation aborts immediately to these values, with no partial results.
- `led` updates on the first `clk` edge where btnr is sampled high after a low sample. Latency is 1 edge.
- `busy` rises on the edge that accepts the final sample and stays high for exactly 80 cycles (32 + 32 + 16).
- `done` rises on the edge that `busy` falls. `busy` and `done` are never high together.
- `done` falls on the edge that accepts a new N.

## Configuration
- `STATS_SEQ_STD_EN`:
  - Defined: `DIV_VAR` and `SQRT` are present, and `busy` lasts 80 cycles.
  - Undefined: the sqrt unit and var datapath are not compiled. `DIV_AVG` goes directly to `DONE`, `busy` lasts 32 cycles, and std always reads 0.

## Test plan
- N=4, samples 1,2,3,4 → sum=10, sumsq=30, avg=2, std=1 (20/16). Display selects 00/01/10/11 show 10/2/30/1.
- N=2, samples 0,10 → avg=5, var=100/4=25, std=5. `busy` is high for exactly 80 cycles, then `done`=1.
- N=255, all samples 255 → internal sum=65025 and sumsq=16581375 with no overflow. Displays: sum=1, avg=255, sumsq=255, std=0.
- First btnc with sw=0 → ignored, state stays `LOAD_N`. btnc pressed during `busy` → results unchanged and no sample consumed. btnc and btnr pressed in the same cycle → `led` shows the pre-update sum.
- Assert `rst` mid-`SQRT` → `led`, `busy` and `done` are 0 asynchronously. The next btnc with sw=3 loads N=3.
- `STATS_SEQ_STD_EN` undefined, N=2, samples 0,10 → `busy` is high for 32 cycles, avg=5, std displays 0.

Source files
------------

// File: rtl/stats_sequencer.sv
// stats_sequencer
// Collects N switch samples, then produces SUM, AVG, SUMSQ and STD.
// One iterative restoring divider is shared between the average and the
// variance, and a bit-serial square-root unit turns the variance into STD.
//
// Ports:
//   clk   in   system clock (125 MHz domain)
//   rst   in   asynchronous active-high reset
//   btnc  in   debounced level, rising edge = enter value (N or a sample)
//   btnr  in   debounced level, rising edge = latch selected value on led
//   sw    in   sample / N value; sw[1:0] selects sum/avg/sumsq/std
//   led   out  registered display value (low 8 bits of the selection)
//   busy  out  computation in progress
//   done  out  results valid
//
// Configuration macro: STATS_SEQ_STD_EN
//   defined   : DIV_VAR and SQRT phases are built, busy lasts 80 cycles
//   undefined : average only, busy lasts 32 cycles, std reads 0
module stats_sequencer #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btnc,
    input  logic              btnr,
    input  logic [DATA_W-1:0] sw,
    output logic [7:0]        led,
    output logic              busy,
    output logic              done
);

    localparam int DW = ACC_W + DATA_W;   // divider / sqrt operand width
    localparam int RW = DW / 2;           // square-root result width

    typedef enum logic [2:0] {
        LOAD_N  = 3'd0,
        COLLECT = 3'd1,
        DIV_AVG = 3'd2,
        DIV_VAR = 3'd3,
        SQRT    = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t            state_r;
    logic              btnc_q_r, btnr_q_r;
    logic [DATA_W-1:0] n_r, rem_cnt_r, avg_r;
    logic [ACC_W-1:0]  sum_r, sumsq_r;
    logic [4:0]        cnt_r;
    logic [7:0]        led_r;
    logic              busy_r, done_r;

    // Shared restoring divider
    logic [DW-1:0]     div_rem_r, div_quo_r, div_den_r;
    logic [DW:0]       div_trial_s;
    logic              div_ge_s;
    logic [DW-1:0]     div_rem_nxt_s, div_quo_nxt_s;

    logic              btnc_press_s, btnr_press_s, load_ok_s;
    logic [ACC_W-1:0]  sum_nxt_s, sumsq_nxt_s, sq_s;
    logic [7:0]        disp_s;

`ifdef STATS_SEQ_STD_EN
    logic [DATA_W-1:0] std_r;
    logic [DW-1:0]     sq_rad_r;
    logic [RW+1:0]     sq_rem_r;
    logic [RW-1:0]     sq_root_r;
    logic [RW+3:0]     sq_sh_s, sq_trial_s;
    logic              sq_ge_s;
    logic [RW+1:0]     sq_rem_nxt_s;
    logic [RW-1:0]     sq_root_nxt_s;
    logic [DW-1:0]     var_num_s, var_den_s;
`endif

    assign led  = led_r;
    assign busy = busy_r;
    assign done = done_r;

    // Button edge detection, accumulator update and one divider step
    always_comb begin
        btnc_press_s  = btnc & ~btnc_q_r;
        btnr_press_s  = btnr & ~btnr_q_r;
        // A new N is only taken while idle, and N=0 is meaningless
        load_ok_s     = btnc_press_s && (sw != '0) &&
                        ((state_r == LOAD_N) || (state_r == DONE));
        sq_s          = ACC_W'(sw) * ACC_W'(sw);
        sum_nxt_s     = sum_r + ACC_W'(sw);
        sumsq_nxt_s   = sumsq_r + sq_s;
        // Shift in the next dividend bit and try subtracting the divisor
        div_trial_s   = {div_rem_r, div_quo_r[DW-1]};
        div_ge_s      = (div_trial_s >= {1'b0, div_den_r});
        div_quo_nxt_s = {div_quo_r[DW-2:0], div_ge_s};
        if (div_ge_s) begin
            div_rem_nxt_s = DW'(div_trial_s - {1'b0, div_den_r});
        end else begin
            div_rem_nxt_s = div_trial_s[DW-1:0];
        end
    end

`ifdef STATS_SEQ_STD_EN
    // Variance operands and one square-root step (two radicand bits per cycle)
    always_comb begin
        // n*sumsq >= sum*sum always holds, so the subtraction cannot wrap
        var_num_s     = DW'(n_r) * DW'(sumsq_r) - DW'(sum_r) * DW'(sum_r);
        var_den_s     = DW'(n_r) * DW'(n_r);
        sq_sh_s       = {sq_rem_r, sq_rad_r[DW-1 -: 2]};
        sq_trial_s    = {2'b00, sq_root_r, 2'b01};
        sq_ge_s       = (sq_sh_s >= sq_trial_s);
        sq_root_nxt_s = {sq_root_r[RW-2:0], sq_ge_s};
        if (sq_ge_s) begin
            sq_rem_nxt_s = (RW+2)'(sq_sh_s - sq_trial_s);
        end else begin
            sq_rem_nxt_s = (RW+2)'(sq_sh_s);
        end
    end
`endif

    // Display selection; avg and std are hidden until results are valid
    always_comb begin
        disp_s = 8'd0;
        case (sw[1:0])
            2'b00:   disp_s = 8'(sum_r);
            2'b01:   disp_s = done_r ? 8'(avg_r) : 8'd0;
            2'b10:   disp_s = 8'(sumsq_r);
`ifdef STATS_SEQ_STD_EN
            2'b11:   disp_s = done_r ? 8'(std_r) : 8'd0;
`else
            2'b11:   disp_s = 8'd0;
`endif
            default: disp_s = 8'd0;
        endcase
    end

    // Sequencer FSM with all datapath registers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= LOAD_N;
            btnc_q_r  <= 1'b0;
            btnr_q_r  <= 1'b0;
            n_r       <= '0;
            rem_cnt_r <= '0;
            sum_r     <= '0;
            sumsq_r   <= '0;
            avg_r     <= '0;
            cnt_r     <= 5'd0;
            div_rem_r <= '0;
            div_quo_r <= '0;
            div_den_r <= '0;
            led_r     <= 8'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
`ifdef STATS_SEQ_STD_EN
            std_r     <= '0;
            sq_rad_r  <= '0;
            sq_rem_r  <= '0;
            sq_root_r <= '0;
`endif
        end else begin
            btnc_q_r <= btnc;
            btnr_q_r <= btnr;
            // Uses pre-update register values, so a same-cycle btnc is not seen
            if (btnr_press_s) begin
                led_r <= disp_s;
            end else begin
                led_r <= led_r;
            end
            case (state_r)
                LOAD_N, DONE: begin
                    if (load_ok_s) begin
                        n_r       <= sw;
                        rem_cnt_r <= sw;
                        sum_r     <= '0;
                        sumsq_r   <= '0;
                        avg_r     <= '0;
`ifdef STATS_SEQ_STD_EN
                        std_r     <= '0;
`endif
                        done_r    <= 1'b0;
                        state_r   <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (btnc_press_s) begin
                        sum_r     <= sum_nxt_s;
                        sumsq_r   <= sumsq_nxt_s;
                        rem_cnt_r <= rem_cnt_r - DATA_W'(1);
                        if (rem_cnt_r == DATA_W'(1)) begin
                            // Final sample: start the average divide right away
                            div_quo_r <= DW'(sum_nxt_s);
                            div_rem_r <= '0;
                            div_den_r <= DW'(n_r);
                            cnt_r     <= 5'd0;
                            busy_r    <= 1'b1;
                            state_r   <= DIV_AVG;
                        end
                    end
                end
                DIV_AVG: begin
                    div_quo_r <= div_quo_nxt_s;
                    div_rem_r <= div_rem_nxt_s;
                    cnt_r     <= cnt_r + 5'd1;
                    if (cnt_r == 5'd31) begin
                        avg_r <= div_quo_nxt_s[DATA_W-1:0];
`ifdef STATS_SEQ_STD_EN
                        div_quo_r <= var_num_s;
                        div_rem_r <= '0;
                        div_den_r <= var_den_s;
                        cnt_r     <= 5'd0;
                        state_r   <= DIV_VAR;
`else
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
`endif
                    end
                end
`ifdef STATS_SEQ_STD_EN
                DIV_VAR: begin
                    div_quo_r <= div_quo_nxt_s;
                    div_rem_r <= div_rem_nxt_s;
                    cnt_r     <= cnt_r + 5'd1;
                    if (cnt_r == 5'd31) begin
                        sq_rad_r  <= div_quo_nxt_s;
                        sq_rem_r  <= '0;
                        sq_root_r <= '0;
                        cnt_r     <= 5'd0;
                        state_r   <= SQRT;
                    end
                end
                SQRT: begin
                    sq_rad_r  <= {sq_rad_r[DW-3:0], 2'b00};
                    sq_rem_r  <= sq_rem_nxt_s;
                    sq_root_r <= sq_root_nxt_s;
                    cnt_r     <= cnt_r + 5'd1;
                    if (cnt_r == 5'd15) begin
                        std_r   <= sq_root_nxt_s[DATA_W-1:0];
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end
                end
`endif
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= LOAD_N;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stats_sequencer.sv
// Directed bench for stats_sequencer: a table of complete runs (N, samples,
// expected displays) plus hand-written sequences for ignored presses,
// simultaneous buttons and reset during computation.
module tb_stats_sequencer;

`ifdef STATS_SEQ_STD_EN
    localparam bit STD_EN   = 1'b1;
    localparam int BUSY_EXP = 80;
`else
    localparam bit STD_EN   = 1'b0;
    localparam int BUSY_EXP = 32;
`endif

    logic       clk, rst, btnc, btnr;
    logic [7:0] sw, led;
    logic       busy, done;

    int checks   = 0;
    int failures = 0;

    stats_sequencer dut (
        .clk  (clk),
        .rst  (rst),
        .btnc (btnc),
        .btnr (btnr),
        .sw   (sw),
        .led  (led),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] n;
        logic [7:0] s0, s1, s2, s3;
        logic [7:0] fill;     // value for samples beyond the fourth
        logic [7:0] e_sum, e_avg, e_sumsq, e_std;
    } row_t;

    row_t rows [4];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One btnc press: high for one rising edge, then low; returns at a negedge
    task automatic press_c(input logic [7:0] v);
        @(negedge clk);
        sw   = v;
        btnc = 1'b1;
        @(negedge clk);
        btnc = 1'b0;
    endtask

    task automatic press_r(input logic [1:0] sel);
        @(negedge clk);
        sw   = {6'd0, sel};
        btnr = 1'b1;
        @(negedge clk);
        btnr = 1'b0;
    endtask

    // Counts negedges with busy high; bounded so a stuck busy still ends
    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy && cyc < 1000) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    function automatic logic [7:0] sample_of(input row_t r, input int i);
        case (i)
            0:       return r.s0;
            1:       return r.s1;
            2:       return r.s2;
            3:       return r.s3;
            default: return r.fill;
        endcase
    endfunction

    initial begin
        int cyc;
        row_t r;

        rows[0] = '{8'd4,   8'd1,   8'd2,   8'd3,   8'd4,   8'd0,   8'd10, 8'd2,   8'd30,  8'd1};
        rows[1] = '{8'd2,   8'd0,   8'd10,  8'd0,   8'd0,   8'd0,   8'd10, 8'd5,   8'd100, 8'd5};
        rows[2] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd1,  8'd255, 8'd255, 8'd0};
        rows[3] = '{8'd3,   8'd7,   8'd8,   8'd12,  8'd0,   8'd0,   8'd27, 8'd9,   8'd1,   8'd2};

        rst  = 1'b1;
        btnc = 1'b0;
        btnr = 1'b0;
        sw   = 8'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_led",  int'(led),  0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);

        // N=0 must be ignored; the first table row then proves LOAD_N held
        press_c(8'd0);
        @(negedge clk);
        chk("zero_n_busy", int'(busy), 0);
        chk("zero_n_done", int'(done), 0);

        for (int k = 0; k < 4; k++) begin
            r = rows[k];
            press_c(r.n);
            chk($sformatf("row%0d_load_done", k), int'(done), 0);
            for (int i = 0; i < int'(r.n); i++) begin
                if (i == int'(r.n) - 1) begin
                    chk($sformatf("row%0d_busy_early", k), int'(busy), 0);
                end
                press_c(sample_of(r, i));
            end
            wait_idle(cyc);
            chk($sformatf("row%0d_busy_len", k), cyc, BUSY_EXP);
            chk($sformatf("row%0d_done", k), int'(done), 1);
            press_r(2'b00);
            chk($sformatf("row%0d_sum", k), int'(led), int'(r.e_sum));
            press_r(2'b01);
            chk($sformatf("row%0d_avg", k), int'(led), int'(r.e_avg));
            press_r(2'b10);
            chk($sformatf("row%0d_sumsq", k), int'(led), int'(r.e_sumsq));
            press_r(2'b11);
            chk($sformatf("row%0d_std", k), int'(led), STD_EN ? int'(r.e_std) : 0);
        end

        // btnc during busy must be neither consumed nor queued
        press_c(8'd2);
        press_c(8'd0);
        press_c(8'd10);
        press_c(8'd99);
        chk("busy_press_busy", int'(busy), 1);
        wait_idle(cyc);
        chk("busy_press_len", cyc + 2, BUSY_EXP);
        press_r(2'b00);
        chk("busy_press_sum", int'(led), 10);
        press_r(2'b01);
        chk("busy_press_avg", int'(led), 5);
        repeat (3) @(negedge clk);
        chk("busy_press_not_queued", int'(done), 1);

        // Simultaneous btnc+btnr: led shows the sum before the new sample
        press_c(8'd2);
        press_c(8'd3);
        @(negedge clk);
        sw   = 8'd8;
        btnc = 1'b1;
        btnr = 1'b1;
        @(negedge clk);
        btnc = 1'b0;
        btnr = 1'b0;
        chk("simul_led_pre", int'(led), 3);
        chk("simul_busy", int'(busy), 1);
        wait_idle(cyc);
        press_r(2'b00);
        chk("simul_sum_post", int'(led), 11);
        press_r(2'b01);
        chk("simul_avg", int'(led), 5);
        press_r(2'b11);
        chk("simul_std", int'(led), STD_EN ? 2 : 0);

        // Reset in the middle of computation (SQRT when built, else DIV_AVG)
        press_c(8'd2);
        press_c(8'd0);
        press_c(8'd10);
        press_r(2'b00);
        chk("midop_led", int'(led), 10);
        repeat (STD_EN ? 66 : 10) @(negedge clk);
        chk("midop_busy", int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_led",  int'(led),  0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        press_c(8'd3);
        press_c(8'd1);
        press_c(8'd1);
        chk("post_rst_n3_not_yet", int'(busy), 0);
        press_c(8'd1);
        chk("post_rst_n3_busy", int'(busy), 1);
        wait_idle(cyc);
        chk("post_rst_len", cyc, BUSY_EXP);
        press_r(2'b01);
        chk("post_rst_avg", int'(led), 1);
        press_r(2'b00);
        chk("post_rst_sum", int'(led), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
